// File: rtl/simple_pkg.sv
// Shared encodings for the SIMPLE core pipeline controller.
// Contents: instruction class and sub-op codes, ALU opcode markers,
// controller state enum, and the decoded-instruction record.
package simple_pkg;

    localparam logic [1:0] CLS_LD  = 2'd0;
    localparam logic [1:0] CLS_ST  = 2'd1;
    localparam logic [1:0] CLS_IMM = 2'd2;
    localparam logic [1:0] CLS_ALU = 2'd3;

    localparam logic [2:0] SUB_LI  = 3'd0;
    localparam logic [2:0] SUB_B   = 3'd4;
    localparam logic [2:0] SUB_BCC = 3'd7;

    localparam logic [3:0] OP_HLT       = 4'd15;
    // ALU opcodes from here up take only one register source.
    localparam logic [3:0] OP_SHIFT_MIN = 4'd9;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    // Up to three source slots; the current ISA never uses more than two,
    // so slot 2 is always disabled by the decoder.
    typedef struct packed {
        logic [2:0]      rd_en;
        logic [2:0][2:0] rd_addr;
        logic            wr_en;
        logic [2:0]      wr_addr;
        logic            is_hlt;
    } dec_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Decode-stage handshake bundle between the core datapath and pipe_ctrl.
//   command/cmd_valid/branch_taken/resume : datapath -> controller
//   issue/pc_en/flush/halted              : controller -> datapath
// master = datapath side, slave = controller side.
interface pipe_ctrl_if;
    logic [15:0] command;
    logic        cmd_valid;
    logic        branch_taken;
    logic        resume;
    logic        issue;
    logic        pc_en;
    logic        flush;
    logic        halted;

    modport master (
        output command, cmd_valid, branch_taken, resume,
        input  issue, pc_en, flush, halted
    );

    modport slave (
        input  command, cmd_valid, branch_taken, resume,
        output issue, pc_en, flush, halted
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one 2-bit down-counter per register.
//   clock, reset    : clock, async active-high reset
//   ld_en, ld_addr  : load ld_addr's counter with WB_LAT
//   rd_addr[2:0]    : three lookup addresses
//   busy[2:0]       : counter at rd_addr[k] is nonzero
//   empty           : every counter is zero
module reg_scoreboard #(
    parameter int WB_LAT = 3,
    parameter int NREG   = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            ld_en,
    input  logic [2:0]      ld_addr,
    input  logic [2:0][2:0] rd_addr,
    output logic [2:0]      busy,
    output logic            empty
);
    localparam logic [1:0] LD_VAL = WB_LAT[1:0];

    logic [1:0] cnt [NREG];

    // A load on the same register as a pending decrement takes priority.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (ld_en && int'(ld_addr) == i)
                    cnt[i] <= LD_VAL;
                else if (cnt[i] != 2'd0)
                    cnt[i] <= cnt[i] - 2'd1;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 3; k++) busy[k] = (cnt[rd_addr[k]] != 2'd0);
    end

    always_comb begin
        empty = 1'b1;
        for (int i = 0; i < NREG; i++)
            if (cnt[i] != 2'd0) empty = 1'b0;
    end
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller beside the decode stage: decodes the
// instruction in decode, checks it against the scoreboard, and decides
// issue / stall / squash; sequences the halt drain and resume.
//   clock, reset : clock, async active-high reset
//   bus (slave)  : command, cmd_valid, branch_taken, resume in;
//                  issue, pc_en, flush, halted out (all combinational)
//
// state   | meaning
// RUN     | normal issue; stall on hazard, squash on taken branch
// DRAIN   | HLT issued; wait for all pending writebacks to land
// HALTED  | core stopped until a resume pulse
module pipe_ctrl
    import simple_pkg::*;
#(
    parameter int WB_LAT = 3,
    parameter int NREG   = 8
) (
    input logic        clock,
    input logic        reset,
    pipe_ctrl_if.slave bus
);
    function automatic dec_t decode(input logic [15:0] cmd);
        dec_t d;
        d = '0;
        case (cmd[15:14])
            CLS_ALU: begin
                d.rd_en[0]   = 1'b1;
                d.rd_addr[0] = cmd[13:11];
                if (cmd[7:4] < OP_SHIFT_MIN) begin
                    d.rd_en[1]   = 1'b1;
                    d.rd_addr[1] = cmd[10:8];
                end
                if (cmd[7:4] == OP_HLT) begin
                    d.is_hlt = 1'b1;
                end else begin
                    d.wr_en   = 1'b1;
                    d.wr_addr = cmd[10:8];
                end
            end
            CLS_LD: begin
                d.rd_en[0]   = 1'b1;
                d.rd_addr[0] = cmd[10:8];
                d.wr_en      = 1'b1;
                d.wr_addr    = cmd[13:11];
            end
            CLS_ST: begin
                d.rd_en[1:0] = 2'b11;
                d.rd_addr[0] = cmd[13:11];
                d.rd_addr[1] = cmd[10:8];
            end
            CLS_IMM: begin
                case (cmd[13:11])
                    SUB_LI: begin
                        d.wr_en   = 1'b1;
                        d.wr_addr = cmd[10:8];
                    end
                    SUB_BCC: begin
                        d.rd_en[0]   = 1'b1;
                        d.rd_addr[0] = cmd[10:8];
                    end
                    default: ;  // B and unused sub-ops touch no registers
                endcase
            end
            default: ;
        endcase
        return d;
    endfunction

    dec_t       dec;
    state_t     state, state_nx;
    logic [2:0] busy;
    logic       sb_empty;
    logic       hazard;
    logic       issue_c, pc_en_c, flush_c, halted_c;

    assign dec    = decode(bus.command);
    assign hazard = |(busy & dec.rd_en);

    reg_scoreboard #(.WB_LAT(WB_LAT), .NREG(NREG)) u_sb (
        .clock   (clock),
        .reset   (reset),
        .ld_en   (issue_c & dec.wr_en),
        .ld_addr (dec.wr_addr),
        .rd_addr (dec.rd_addr),
        .busy    (busy),
        .empty   (sb_empty)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_RUN;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        issue_c  = 1'b0;
        pc_en_c  = 1'b0;
        flush_c  = 1'b0;
        halted_c = 1'b0;
        case (state)
            ST_RUN: begin
                // A taken branch squashes decode even if it was stalled,
                // and the PC moves on to the branch target.
                flush_c = bus.branch_taken;
                issue_c = bus.cmd_valid & ~hazard & ~flush_c;
                pc_en_c = ~(bus.cmd_valid & hazard) | flush_c;
                if (issue_c && dec.is_hlt) state_nx = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (sb_empty) state_nx = ST_HALTED;
            end
            ST_HALTED: begin
                halted_c = 1'b1;
                if (bus.resume) state_nx = ST_RUN;
            end
            default: state_nx = ST_RUN;
        endcase
    end

    assign bus.issue  = issue_c;
    assign bus.pc_en  = pc_en_c;
    assign bus.flush  = flush_c;
    assign bus.halted = halted_c;
endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;
    localparam int WB_LAT = 3;

    logic clock = 1'b0;
    logic reset;

    pipe_ctrl_if bus ();

    pipe_ctrl #(.WB_LAT(WB_LAT), .NREG(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #10 clock = ~clock;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: cycle index at which each register's writeback is
    // complete, plus a coarse mode (0 run, 1 draining, 2 halted).
    int cyc;
    int free_at [8];
    int mode;

    task automatic chk(input string tag, input logic got, input logic exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 8; r++) free_at[r] = 0;
        mode = 0;
    endtask

    task automatic drv(input logic [15:0] c, input logic v, input logic bt, input logic rs);
        bus.command      = c;
        bus.cmd_valid    = v;
        bus.branch_taken = bt;
        bus.resume       = rs;
    endtask

    function automatic void tb_decode(input logic [15:0] c, output logic [7:0] rmask,
                                      output bit wr, output int dst, output bit hlt);
        int cls, a, b, op;
        cls = int'(c[15:14]);
        a   = int'(c[13:11]);
        b   = int'(c[10:8]);
        op  = int'(c[7:4]);
        rmask = '0; wr = 0; dst = 0; hlt = 0;
        if (cls == 3) begin
            rmask[a] = 1'b1;
            if (op <= 8) rmask[b] = 1'b1;
            if (op == 15) hlt = 1;
            else begin wr = 1; dst = b; end
        end else if (cls == 0) begin
            rmask[b] = 1'b1; wr = 1; dst = a;
        end else if (cls == 1) begin
            rmask[a] = 1'b1; rmask[b] = 1'b1;
        end else if (a == 0) begin
            wr = 1; dst = b;
        end else if (a == 7) begin
            rmask[b] = 1'b1;
        end
    endfunction

    function automatic bit hazard_now(input logic [7:0] m);
        for (int r = 0; r < 8; r++)
            if (m[r] && free_at[r] > cyc) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit all_free();
        for (int r = 0; r < 8; r++)
            if (free_at[r] > cyc) return 1'b0;
        return 1'b1;
    endfunction

    // Called just after a falling edge with inputs driven: checks all
    // outputs against the model, then advances model and DUT one cycle.
    task automatic step(input string tag);
        logic [7:0] m;
        bit   wr, hlt, hz;
        int   dst;
        logic e_issue, e_pc, e_fl, e_h;
        tb_decode(bus.command, m, wr, dst, hlt);
        hz = hazard_now(m);
        e_issue = 1'b0; e_pc = 1'b0; e_fl = 1'b0; e_h = 1'b0;
        if (mode == 0) begin
            e_fl    = bus.branch_taken;
            e_issue = bus.cmd_valid & !hz & !e_fl;
            e_pc    = !(bus.cmd_valid & hz) | e_fl;
        end else if (mode == 2) begin
            e_h = 1'b1;
        end
        #1;
        chk({tag, ".issue"},  bus.issue,  e_issue);
        chk({tag, ".pc_en"},  bus.pc_en,  e_pc);
        chk({tag, ".flush"},  bus.flush,  e_fl);
        chk({tag, ".halted"}, bus.halted, e_h);
        @(posedge clock);
        if (mode == 0 && e_issue && wr) free_at[dst] = cyc + WB_LAT + 1;
        if (mode == 0 && e_issue && hlt)   mode = 1;
        else if (mode == 1 && all_free())  mode = 2;
        else if (mode == 2 && bus.resume)  mode = 0;
        cyc++;
        @(negedge clock);
    endtask

    // Fixed expectations straight from the intended behaviour.
    task automatic expect_io(input string tag, input logic i, input logic p,
                             input logic f, input logic h);
        #1;
        chk({tag, ".x_issue"},  bus.issue,  i);
        chk({tag, ".x_pc_en"},  bus.pc_en,  p);
        chk({tag, ".x_flush"},  bus.flush,  f);
        chk({tag, ".x_halted"}, bus.halted, h);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] c;
        cyc = 0;
        model_reset();
        reset = 1'b1;
        drv(16'h0000, 1'b0, 1'b0, 1'b0);
        expect_io("reset", 1'b0, 1'b1, 1'b0, 1'b0);
        #25 reset = 1'b0;
        @(negedge clock);

        // Back-to-back RAW: LI r1 then ADD reading r1.
        drv(16'h8100, 1, 0, 0); expect_io("raw_li", 1, 1, 0, 0); step("raw_li");
        drv(16'hC808, 1, 0, 0);
        for (int k = 1; k <= 3; k++) begin
            expect_io($sformatf("raw_stall%0d", k), 0, 0, 0, 0); step("raw_stall");
        end
        expect_io("raw_issue_t4", 1, 1, 0, 0); step("raw_issue");

        // Independent LIs stream with no stall.
        drv(16'h8100, 1, 0, 0); expect_io("li_r1", 1, 1, 0, 0); step("li_r1");
        drv(16'h8200, 1, 0, 0); expect_io("li_r2", 1, 1, 0, 0); step("li_r2");
        drv(16'h8300, 1, 0, 0); expect_io("li_r3", 1, 1, 0, 0); step("li_r3");

        // ST with r1 pending stalls.
        drv(16'h4A00, 1, 0, 0); expect_io("st_stall", 0, 0, 0, 0); step("st_stall");
        // Stalled ALU writing r5, hit by a taken branch: squash, no load.
        drv(16'hDD00, 1, 1, 0); expect_io("flush_stall", 0, 1, 1, 0); step("flush_stall");
        drv(16'hBD00, 1, 0, 0); expect_io("no_load_r5", 1, 1, 0, 0); step("no_load_r5");
        // Shift reads only [13:11]; a pending [10:8] must not stall it.
        drv(16'h8400, 1, 0, 0); step("li_r4");
        drv(16'hF4A0, 1, 0, 0); expect_io("shift_nostall", 1, 1, 0, 0); step("shift");
        drv(16'hF480, 1, 0, 0); expect_io("op8_stall", 0, 0, 0, 0); step("op8_stall");
        drv(16'hF480, 0, 0, 1); expect_io("bubble_run", 0, 1, 0, 0); step("bubble_run");
        for (int k = 0; k < 4; k++) step("idle");

        // Halt drain and resume.
        drv(16'h1000, 1, 0, 0); expect_io("ld_r2", 1, 1, 0, 0); step("ld_r2");
        drv(16'hC0F0, 1, 0, 0); expect_io("hlt", 1, 1, 0, 0); step("hlt");
        drv(16'h8100, 1, 1, 0); expect_io("drain1", 0, 0, 0, 0); step("drain1");
        drv(16'h8100, 1, 0, 1); expect_io("drain2_resume", 0, 0, 0, 0); step("drain2");
        drv(16'h8100, 1, 0, 0); expect_io("drain3", 0, 0, 0, 0); step("drain3");
        drv(16'h8100, 1, 1, 0); expect_io("halted", 0, 0, 0, 1); step("halted");
        drv(16'h8100, 0, 0, 1); expect_io("halted_resume", 0, 0, 0, 1); step("resume");
        drv(16'h8100, 0, 0, 0); expect_io("run_again", 0, 1, 0, 0); step("run_again");

        // Async reset mid-stall with r1 counter at 2.
        drv(16'h8100, 1, 0, 0); step("rst_li");
        drv(16'hC808, 1, 0, 0); step("rst_stall1");
        expect_io("rst_stall2", 0, 0, 0, 0);
        #1 reset = 1'b1;
        #1;
        chk("rst_async.pc_en", bus.pc_en, 1'b1);
        chk("rst_async.flush", bus.flush, 1'b0);
        chk("rst_async.halted", bus.halted, 1'b0);
        bus.cmd_valid = 1'b0;
        #1 chk("rst_async.issue", bus.issue, 1'b0);
        #1 reset = 1'b0;
        model_reset();
        bus.cmd_valid = 1'b1;
        expect_io("add_after_reset", 1, 1, 0, 0); step("add_after_reset");
        drv(16'h0000, 0, 0, 0);
        for (int k = 0; k < 4; k++) step("idle2");

        // Async reset mid-drain.
        drv(16'h1000, 1, 0, 0); step("d_ld");
        drv(16'hC0F0, 1, 0, 0); step("d_hlt");
        drv(16'h0000, 0, 0, 0); expect_io("d_drain", 0, 0, 0, 0);
        #1 reset = 1'b1;
        #1;
        chk("drain_rst.pc_en", bus.pc_en, 1'b1);
        chk("drain_rst.halted", bus.halted, 1'b0);
        #1 reset = 1'b0;
        model_reset();
        drv(16'h1200, 1, 0, 0); expect_io("ld_after_drain_rst", 1, 1, 0, 0); step("ld_after_rst");

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                c = 16'hC0F0;
                c[13:11] = 3'($urandom_range(0, 7));
            end else begin
                c = 16'($urandom);
            end
            drv(c, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 3) == 0);
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
